// File: rtl/pipe_pkg.sv
// Shared types and constants for the skid-buffered pipeline stage register.
// Holds the occupancy state encoding, default widths and control bit positions.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 96;
  localparam int DEF_CTRL_W = 4;
  localparam int DEF_CNT_W  = 16;

  // Positions of the standard enables inside the control field.
  localparam int CTRL_WB  = 0;
  localparam int CTRL_MR  = 1;
  localparam int CTRL_MW  = 2;
  localparam int CTRL_IMM = 3;

endpackage

// File: rtl/pipe_stage_skid_reg_sat_counter.sv
// Saturating up-counter with a synchronous active-low clear.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Valid/ready pipeline stage register with a one-entry skid behind the main
// output register, so in_ready comes straight from a flop.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid must not depend on ready, and a held entry is never changed
// while valid is high and ready is low.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output state_t            fsm_state
);

  state_t              state_q, state_n;
  logic                main_valid_q, main_valid_n;
  logic [DATA_W-1:0]   main_data_q, main_data_n;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_n;
  logic [DATA_W-1:0]   skid_data_q, skid_data_n;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_n;
  logic                in_ready_q;
  logic                in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = main_valid_q & out_ready;

  always_comb begin
    state_n      = state_q;
    main_valid_n = main_valid_q;
    main_data_n  = main_data_q;
    main_ctrl_n  = main_ctrl_q;
    skid_data_n  = skid_data_q;
    skid_ctrl_n  = skid_ctrl_q;
    if (flush) begin
      // Data words may keep stale contents; only validity and control die.
      state_n      = EMPTY;
      main_valid_n = 1'b0;
      main_ctrl_n  = '0;
      skid_ctrl_n  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_valid_n = 1'b1;
            main_data_n  = in_data;
            main_ctrl_n  = in_ctrl;
            state_n      = ONE;
          end
        end
        ONE: begin
          case ({in_xfer, out_xfer})
            2'b11: begin
              main_data_n = in_data;
              main_ctrl_n = in_ctrl;
            end
            2'b10: begin
              skid_data_n = in_data;
              skid_ctrl_n = in_ctrl;
              state_n     = FULL;
            end
            2'b01: begin
              main_valid_n = 1'b0;
              main_ctrl_n  = '0;
              state_n      = EMPTY;
            end
            default: ;
          endcase
        end
        FULL: begin
          // in_ready is low here, so only the drain of the skid can happen.
          if (out_xfer) begin
            main_data_n = skid_data_q;
            main_ctrl_n = skid_ctrl_q;
            skid_ctrl_n = '0;
            state_n     = ONE;
          end
        end
        default: begin
          state_n      = EMPTY;
          main_valid_n = 1'b0;
          main_ctrl_n  = '0;
          skid_ctrl_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= EMPTY;
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_n;
      main_valid_q <= main_valid_n;
      main_data_q  <= main_data_n;
      main_ctrl_q  <= main_ctrl_n;
      skid_data_q  <= skid_data_n;
      skid_ctrl_q  <= skid_ctrl_n;
      in_ready_q   <= (state_n != FULL);
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (main_valid_q & ~out_ready),
    .count(stall_cnt)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg: reset, streaming, backpressure,
// flush, bubbles and stall-counter saturation on a narrow-counter instance.
module tb_pipe_stage_skid_reg;
  import pipe_pkg::*;

  localparam int DATA_W = 96;
  localparam int CTRL_W = 4;

  // Clock / reset block
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic              out_ready = 1'b1;
  logic              out_ready_s = 1'b1;

  logic              in_ready, out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [15:0]       stall_cnt;
  state_t            fsm_state;

  logic              in_ready_s, out_valid_s;
  logic [DATA_W-1:0] out_data_s;
  logic [CTRL_W-1:0] out_ctrl_s;
  logic [2:0]        stall_cnt_s;
  state_t            fsm_state_s;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt), .fsm_state(fsm_state)
  );

  pipe_stage_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid_s), .out_ready(out_ready_s), .out_data(out_data_s), .out_ctrl(out_ctrl_s),
    .stall_cnt(stall_cnt_s), .fsm_state(fsm_state_s)
  );

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    // Reset held for 3 cycles with upstream trying to push.
    push(96'h55, 4'hF);
    repeat (3) begin
      tick();
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_out_ctrl", 128'(out_ctrl), 128'(0));
      chk("rst_in_ready", 128'(in_ready), 128'(0));
      chk("rst_stall", 128'(stall_cnt), 128'(0));
    end
    chk("rst_out_data", 128'(out_data), 128'(0));
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("rel_in_ready", 128'(in_ready), 128'(1));
    chk("rel_state", 128'(fsm_state), 128'(EMPTY));

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      push(DATA_W'(i), 4'b0101);
      tick();
      chk("stream_valid", 128'(out_valid), 128'(1));
      chk("stream_data", 128'(out_data), 128'(i));
      chk("stream_ctrl", 128'(out_ctrl), 128'(4'b0101));
      chk("stream_in_ready", 128'(in_ready), 128'(1));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain_valid", 128'(out_valid), 128'(0));
    chk("stream_drain_ctrl", 128'(out_ctrl), 128'(0));
    chk("stream_drain_state", 128'(fsm_state), 128'(EMPTY));

    // Bubbles must never leak control.
    in_valid = 1'b0;
    in_ctrl  = 4'hF;
    repeat (5) begin
      tick();
      chk("bubble_ctrl", 128'(out_ctrl), 128'(0));
      chk("bubble_valid", 128'(out_valid), 128'(0));
    end

    // Backpressure: A presented, then 4 stalled cycles.
    push(96'hA, 4'h3);
    tick();
    chk("bp_a_data", 128'(out_data), 128'(96'hA));
    out_ready = 1'b0;
    push(96'hB, 4'h3);
    tick();
    chk("bp_skid_state", 128'(fsm_state), 128'(FULL));
    chk("bp_skid_in_ready", 128'(in_ready), 128'(0));
    chk("bp_stall1", 128'(stall_cnt), 128'(1));
    push(96'hC, 4'h3);
    repeat (3) begin
      tick();
      chk("bp_hold_data", 128'(out_data), 128'(96'hA));
      chk("bp_hold_ctrl", 128'(out_ctrl), 128'(4'h3));
      chk("bp_hold_in_ready", 128'(in_ready), 128'(0));
      chk("bp_hold_state", 128'(fsm_state), 128'(FULL));
    end
    chk("bp_stall4", 128'(stall_cnt), 128'(4));
    out_ready = 1'b1;
    tick();
    chk("bp_rel_b", 128'(out_data), 128'(96'hB));
    chk("bp_rel_state", 128'(fsm_state), 128'(ONE));
    chk("bp_rel_in_ready", 128'(in_ready), 128'(1));
    tick();
    chk("bp_rel_c", 128'(out_data), 128'(96'hC));
    chk("bp_rel_c_valid", 128'(out_valid), 128'(1));
    in_valid = 1'b0;
    tick();
    chk("bp_empty_valid", 128'(out_valid), 128'(0));
    chk("bp_stall_kept", 128'(stall_cnt), 128'(4));

    // Flush while FULL, with a live input in the flush cycle.
    out_ready = 1'b0;
    push(96'hD, 4'h1);
    tick();
    push(96'hE, 4'h2);
    tick();
    chk("fl_pre_state", 128'(fsm_state), 128'(FULL));
    chk("fl_pre_stall", 128'(stall_cnt), 128'(5));
    flush = 1'b1;
    push(96'hF0, 4'hF);
    tick();
    chk("fl_valid", 128'(out_valid), 128'(0));
    chk("fl_ctrl", 128'(out_ctrl), 128'(0));
    chk("fl_in_ready", 128'(in_ready), 128'(1));
    chk("fl_state", 128'(fsm_state), 128'(EMPTY));
    chk("fl_stall_kept", 128'(stall_cnt), 128'(6));
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) begin
      tick();
      chk("fl_no_ghost", 128'(out_valid), 128'(0));
      chk("fl_no_ghost_ctrl", 128'(out_ctrl), 128'(0));
    end

    // Saturation on the 3-bit counter instance.
    chk("sat_start", 128'(stall_cnt_s), 128'(0));
    out_ready_s = 1'b0;
    push(96'h77, 4'h1);
    tick();
    chk("sat_loaded", 128'(out_valid_s), 128'(1));
    in_valid = 1'b0;
    repeat (3) tick();
    chk("sat_cnt3", 128'(stall_cnt_s), 128'(3));
    repeat (7) tick();
    chk("sat_cnt7", 128'(stall_cnt_s), 128'(7));
    chk("sat_hold_data", 128'(out_data_s), 128'(96'h77));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sat_flush_cnt", 128'(stall_cnt_s), 128'(7));
    chk("sat_flush_valid", 128'(out_valid_s), 128'(0));
    chk("main_stall_final", 128'(stall_cnt), 128'(6));

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
